// File: rtl/alsu_cmd_issuer.sv
// Initiator for the ALSU: buffers packed commands, drives one ALSU operation per clock
// (single or six-step sweep) and returns tagged, latency-aligned responses in issue order.
module alsu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 8,
    parameter int TAG_W     = 4,
    parameter int ALSU_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [17+TAG_W-1:0]   cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [2:0]            rsp_opcode,
    output logic signed [5:0]     rsp_out,
    output logic [15:0]           rsp_leds,
    output logic                  alsu_rst,
    output logic [2:0]            alsu_opcode,
    output logic signed [2:0]     alsu_A,
    output logic signed [2:0]     alsu_B,
    output logic                  alsu_cin,
    output logic                  alsu_red_op_A,
    output logic                  alsu_red_op_B,
    output logic                  alsu_bypass_A,
    output logic                  alsu_bypass_B,
    output logic                  alsu_direction,
    output logic                  alsu_serial_in,
    input  logic signed [5:0]     alsu_out,
    input  logic [15:0]           alsu_leds
);

    localparam int CMD_W  = 17 + TAG_W;
    localparam int CAW    = $clog2(CMD_DEPTH);
    localparam int RAW    = $clog2(RSP_DEPTH);
    localparam int CRW    = $clog2(RSP_DEPTH + 1);
    localparam int OPS_W  = 13;
    localparam int RSP_W  = TAG_W + 3 + 6 + 16;
    localparam int PIPE_N = ALSU_LAT + 1;

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    state_t             state_q;
    logic [2:0]         idx_q;
    logic [TAG_W-1:0]   swp_tag_q;
    logic [OPS_W-1:0]   swp_ops_q;
    logic               alsu_rst_q;
    logic [2:0]         alsu_op_q;
    logic [OPS_W-1:0]   alsu_ops_q;

    logic [CMD_W-1:0]   cmd_mem_q [CMD_DEPTH];
    logic [CAW-1:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CAW:0]       cmd_cnt_q, cmd_cnt_d;

    logic [RSP_W-1:0]   rsp_mem_q [RSP_DEPTH];
    logic [RAW-1:0]     rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RAW:0]       rsp_cnt_q, rsp_cnt_d;

    logic [CRW-1:0]     credits_q, credits_d;

    logic [PIPE_N-1:0]  pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_tag_q [PIPE_N];
    logic [TAG_W-1:0]   pipe_tag_d [PIPE_N];
    logic [2:0]         pipe_op_q  [PIPE_N];
    logic [2:0]         pipe_op_d  [PIPE_N];

    logic               cmd_push, cmd_pop, rsp_push, rsp_pop;
    logic               can_issue, issue_single, start_sweep, in_sweep, issue;
    logic [CMD_W-1:0]   head;
    logic [TAG_W-1:0]   head_tag, issue_tag;
    logic               head_sweep;
    logic [2:0]         head_op, issue_op;
    logic [OPS_W-1:0]   head_ops, issue_ops;
    logic [RSP_W-1:0]   rsp_head;

    assign cmd_ready = !alsu_rst_q && (cmd_cnt_q != (CAW+1)'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_cnt_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = pipe_vld_q[PIPE_N-1];

    assign head       = cmd_mem_q[cmd_rd_q];
    assign head_tag   = head[CMD_W-1 -: TAG_W];
    assign head_sweep = head[16];
    assign head_op    = head[15:13];
    assign head_ops   = head[12:0];

    // Issue decision: a sweep only starts once all six response slots are reserved.
    always_comb begin
        in_sweep     = (state_q == SWEEP);
        can_issue    = !alsu_rst_q && (state_q == IDLE) && (cmd_cnt_q != '0);
        issue_single = can_issue && !head_sweep && (credits_q >= CRW'(1));
        start_sweep  = can_issue && head_sweep && (credits_q >= CRW'(6));
        cmd_pop      = issue_single || start_sweep;
        issue        = cmd_pop || in_sweep;
        issue_tag    = in_sweep ? swp_tag_q : head_tag;
        issue_ops    = in_sweep ? swp_ops_q : head_ops;
        if (in_sweep)
            issue_op = idx_q;
        else if (start_sweep)
            issue_op = 3'd0;
        else
            issue_op = head_op;
    end

    always_comb begin
        cmd_wr_d  = cmd_wr_q + CAW'(cmd_push);
        cmd_rd_d  = cmd_rd_q + CAW'(cmd_pop);
        cmd_cnt_d = cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
        rsp_wr_d  = rsp_wr_q + RAW'(rsp_push);
        rsp_rd_d  = rsp_rd_q + RAW'(rsp_pop);
        rsp_cnt_d = rsp_cnt_q + (RAW+1)'(rsp_push) - (RAW+1)'(rsp_pop);
        credits_d = credits_q - CRW'(issue) + CRW'(rsp_pop);
        pipe_vld_d   = {pipe_vld_q[PIPE_N-2:0], issue};
        pipe_tag_d[0] = issue_tag;
        pipe_op_d[0]  = issue_op;
        for (int i = 1; i < PIPE_N; i++) begin
            pipe_tag_d[i] = pipe_tag_q[i-1];
            pipe_op_d[i]  = pipe_op_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_cnt_q  <= '0;
            rsp_wr_q   <= '0;
            rsp_rd_q   <= '0;
            rsp_cnt_q  <= '0;
            credits_q  <= CRW'(RSP_DEPTH);
            pipe_vld_q <= '0;
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_tag_q[i] <= '0;
                pipe_op_q[i]  <= '0;
            end
        end else begin
            cmd_wr_q   <= cmd_wr_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_cnt_q  <= rsp_cnt_d;
            credits_q  <= credits_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_tag_q[i] <= pipe_tag_d[i];
                pipe_op_q[i]  <= pipe_op_d[i];
            end
        end
    end

    // Storage arrays hold data only; emptiness is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem_q[cmd_wr_q] <= cmd_data;
        if (rsp_push)
            rsp_mem_q[rsp_wr_q] <= {pipe_tag_q[PIPE_N-1], pipe_op_q[PIPE_N-1], alsu_out, alsu_leds};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            swp_tag_q  <= '0;
            swp_ops_q  <= '0;
            alsu_rst_q <= 1'b1;
            alsu_op_q  <= '0;
            alsu_ops_q <= '0;
        end else begin
            alsu_rst_q <= 1'b0;
            alsu_op_q  <= issue ? issue_op  : 3'd0;
            alsu_ops_q <= issue ? issue_ops : '0;
            case (state_q)
                IDLE: begin
                    if (start_sweep) begin
                        swp_tag_q <= head_tag;
                        swp_ops_q <= head_ops;
                        idx_q     <= 3'd1;
                        state_q   <= SWEEP;
                    end
                end
                SWEEP: begin
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd5)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alsu_rst       = alsu_rst_q;
    assign alsu_opcode    = alsu_op_q;
    assign alsu_A         = $signed(alsu_ops_q[12:10]);
    assign alsu_B         = $signed(alsu_ops_q[9:7]);
    assign alsu_cin       = alsu_ops_q[6];
    assign alsu_red_op_A  = alsu_ops_q[5];
    assign alsu_red_op_B  = alsu_ops_q[4];
    assign alsu_bypass_A  = alsu_ops_q[3];
    assign alsu_bypass_B  = alsu_ops_q[2];
    assign alsu_direction = alsu_ops_q[1];
    assign alsu_serial_in = alsu_ops_q[0];

    assign rsp_head   = rsp_mem_q[rsp_rd_q];
    assign rsp_tag    = rsp_valid ? rsp_head[RSP_W-1 -: TAG_W] : '0;
    assign rsp_opcode = rsp_valid ? rsp_head[24:22] : '0;
    assign rsp_out    = rsp_valid ? $signed(rsp_head[21:16]) : '0;
    assign rsp_leds   = rsp_valid ? rsp_head[15:0] : '0;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: a small ALSU model closes the loop, directed commands push
// hand-computed responses into a queue that a negedge monitor pops and compares.
module tb_alsu_cmd_issuer;

    localparam int TAG_W = 4;
    localparam int CMD_W = 17 + TAG_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [CMD_W-1:0]   cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [TAG_W-1:0]   rsp_tag;
    logic [2:0]         rsp_opcode;
    logic signed [5:0]  rsp_out;
    logic [15:0]        rsp_leds;
    logic               alsu_rst;
    logic [2:0]         alsu_opcode;
    logic signed [2:0]  alsu_A, alsu_B;
    logic               alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic               alsu_direction, alsu_serial_in;
    logic signed [5:0]  alsu_out = '0;
    logic [15:0]        alsu_leds = '0;

    alsu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(8), .TAG_W(TAG_W), .ALSU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_opcode(rsp_opcode), .rsp_out(rsp_out), .rsp_leds(rsp_leds),
        .alsu_rst(alsu_rst), .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    always #5 clk = ~clk;

    // ALSU model: inputs registered on one edge, out/leds updated on the next.
    logic [2:0]        m_op = '0;
    logic signed [2:0] m_A = '0, m_B = '0;
    logic              m_cin = 0, m_rA = 0, m_rB = 0, m_bA = 0, m_bB = 0, m_dir = 0, m_sin = 0;

    function automatic logic [21:0] alsu_eval(input logic [2:0] op, input logic signed [2:0] a,
                                              input logic signed [2:0] b, input logic cin,
                                              input logic ra, input logic rb, input logic ba,
                                              input logic bb, input logic dir, input logic sin,
                                              input logic [5:0] prev);
        logic signed [5:0] r;
        r = '0;
        if (op > 3'd5) return {16'hFFFF, 6'd0};
        if (ba) r = a;
        else if (bb) r = b;
        else begin
            case (op)
                3'd0: if (ra) r = {5'b0, |a}; else if (rb) r = {5'b0, |b}; else r = a | b;
                3'd1: if (ra) r = {5'b0, ^a}; else if (rb) r = {5'b0, ^b}; else r = a ^ b;
                3'd2: r = a + b + $signed({1'b0, cin});
                3'd3: r = a * b;
                3'd4: r = dir ? {prev[4:0], sin} : {sin, prev[5:1]};
                default: r = dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            endcase
        end
        return {16'h0000, r};
    endfunction

    always @(posedge clk) begin
        if (alsu_rst) begin
            m_op <= '0; m_A <= '0; m_B <= '0; m_cin <= 0; m_rA <= 0; m_rB <= 0;
            m_bA <= 0; m_bB <= 0; m_dir <= 0; m_sin <= 0;
            alsu_out <= '0; alsu_leds <= '0;
        end else begin
            m_op <= alsu_opcode; m_A <= alsu_A; m_B <= alsu_B; m_cin <= alsu_cin;
            m_rA <= alsu_red_op_A; m_rB <= alsu_red_op_B; m_bA <= alsu_bypass_A;
            m_bB <= alsu_bypass_B; m_dir <= alsu_direction; m_sin <= alsu_serial_in;
            {alsu_leds, alsu_out} <= alsu_eval(m_op, m_A, m_B, m_cin, m_rA, m_rB, m_bA, m_bB,
                                               m_dir, m_sin, alsu_out);
        end
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
        logic [5:0]       out;
        logic [15:0]      leds;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got tag=%0d op=%0d out=%0h leds=%0h, required no response",
                         rsp_tag, rsp_opcode, rsp_out, rsp_leds);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_tag, rsp_opcode, rsp_out, rsp_leds} !== mon_e) begin
                    n_err++;
                    $display("FAIL rsp_check: got tag=%0d op=%0d out=%0h leds=%0h, required tag=%0d op=%0d out=%0h leds=%0h",
                             rsp_tag, rsp_opcode, rsp_out, rsp_leds, mon_e.tag, mon_e.op, mon_e.out, mon_e.leds);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CMD_W-1:0] pack(input logic [3:0] tag, input logic sweep,
                                              input logic [2:0] op, input logic [2:0] a,
                                              input logic [2:0] b, input logic cin,
                                              input logic dir, input logic sin);
        return {tag, sweep, op, a, b, cin, 4'b0000, dir, sin};
    endfunction

    task automatic push_exp(input logic [3:0] tag, input logic [2:0] op,
                            input logic [5:0] out, input logic [15:0] leds);
        exp_q.push_back({tag, op, out, leds});
    endtask

    task automatic send(input logic [CMD_W-1:0] d);
        bit ok;
        ok = 1'b0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ok = cmd_ready;
            tick(1);
            if (ok) break;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 100 cycles, required 1");
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("rsp_drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // reset held with a command offered
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = pack(4'd9, 1'b0, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("rst_alsu_rst", 32'(alsu_rst), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alsu_opcode", 32'(alsu_opcode), 32'd0);
        check("rst_rsp_leds", 32'(rsp_leds), 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        check("rel_cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
        tick(1);
        check("rel_alsu_rst", 32'(alsu_rst), 32'd0);
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        tick(2);
        check("rel_no_rsp", 32'(rsp_valid), 32'd0);

        // single ADD: 3 + (-2) + 1 = 2
        push_exp(4'd5, 3'd2, 6'd2, 16'h0000);
        send(pack(4'd5, 1'b0, 3'd2, 3'd3, 3'b110, 1'b1, 1'b0, 1'b0));
        tick(1);
        check("add_alsu_opcode", 32'(alsu_opcode), 32'd2);
        check("add_alsu_A", 32'($unsigned(alsu_A)), 32'd3);
        tick(2);
        check("add_lat_early", 32'(rsp_valid), 32'd0);
        tick(1);
        check("add_lat_valid", 32'(rsp_valid), 32'd1);
        wait_drain(20);

        // sweep A=1 B=2 dir=1 sin=1; opcode field ignored
        push_exp(4'd3, 3'd0, 6'd3, 16'h0);
        push_exp(4'd3, 3'd1, 6'd3, 16'h0);
        push_exp(4'd3, 3'd2, 6'd3, 16'h0);
        push_exp(4'd3, 3'd3, 6'd2, 16'h0);
        push_exp(4'd3, 3'd4, 6'd5, 16'h0);
        push_exp(4'd3, 3'd5, 6'd10, 16'h0);
        send(pack(4'd3, 1'b1, 3'd7, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("sweep_alsu_opcode", 32'(alsu_opcode), 32'(k));
        end
        tick(1);
        check("sweep_after_idle_A", 32'($unsigned(alsu_A)), 32'd0);
        check("sweep_after_idle_op", 32'(alsu_opcode), 32'd0);
        wait_drain(20);

        // invalid opcode 6 after idle, then single SHIFT left of out=0 with serial_in=1
        tick(3);
        push_exp(4'd1, 3'd6, 6'd0, 16'hFFFF);
        send(pack(4'd1, 1'b0, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        wait_drain(20);
        tick(2);
        push_exp(4'd2, 3'd4, 6'd1, 16'h0);
        send(pack(4'd2, 1'b0, 3'd4, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1));
        wait_drain(20);

        // backpressure with two sweeps queued
        rsp_ready = 1'b0;
        push_exp(4'd7, 3'd0, 6'd3, 16'h0);
        push_exp(4'd7, 3'd1, 6'd3, 16'h0);
        push_exp(4'd7, 3'd2, 6'd3, 16'h0);
        push_exp(4'd7, 3'd3, 6'd2, 16'h0);
        push_exp(4'd7, 3'd4, 6'd5, 16'h0);
        push_exp(4'd7, 3'd5, 6'd10, 16'h0);
        push_exp(4'd8, 3'd0, 6'h3F, 16'h0);
        push_exp(4'd8, 3'd1, 6'h3E, 16'h0);
        push_exp(4'd8, 3'd2, 6'h00, 16'h0);
        push_exp(4'd8, 3'd3, 6'h3F, 16'h0);
        push_exp(4'd8, 3'd4, 6'h1F, 16'h0);
        push_exp(4'd8, 3'd5, 6'h2F, 16'h0);
        send(pack(4'd7, 1'b1, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1));
        send(pack(4'd8, 1'b1, 3'd0, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0));
        tick(12);
        check("bp_idle_opcode", 32'(alsu_opcode), 32'd0);
        check("bp_idle_A", 32'($unsigned(alsu_A)), 32'd0);
        check("bp_idle_B", 32'($unsigned(alsu_B)), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_head_tag", 32'(rsp_tag), 32'd7);
        rsp_ready = 1'b1;
        wait_drain(80);
        tick(8);
        check("bp_no_extra", 32'(rsp_valid), 32'd0);

        // reset after the third sweep issue, with one response already queued
        rsp_ready = 1'b0;
        send(pack(4'd4, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0));
        tick(5);
        check("mid_pre_valid", 32'(rsp_valid), 32'd1);
        send(pack(4'd6, 1'b1, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1));
        tick(3);
        check("mid_third_issue", 32'(alsu_opcode), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_alsu_rst", 32'(alsu_rst), 32'd1);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick(10);
        check("mid_no_stale", 32'(rsp_valid), 32'd0);
        // XOR -3 ^ 3 = 3'b110 -> -2
        push_exp(4'd11, 3'd1, 6'h3E, 16'h0);
        send(pack(4'd11, 1'b0, 3'd1, 3'b101, 3'b011, 1'b0, 1'b0, 1'b0));
        wait_drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
